// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, plus the
// pending-register scoreboard that decode uses for claims and RAW stalls.
module regfile_wb_arbiter #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic                      claim_valid,
   input  logic [ADDR_W-1:0]         claim_addr,
   output logic                      claim_ready,
   input  logic [ADDR_W-1:0]         rs_addr,
   input  logic [ADDR_W-1:0]         rt_addr,
   output logic                      stall,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic [31:0]               busy
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]  ptr_r;
   logic [PTR_W-1:0]  cand_s;
   logic [PTR_W-1:0]  gnt_idx_s;
   logic              found_s;
   logic [N_REQ-1:0]  grant_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_data_s;
   logic [31:0]       busy_r;
   logic [31:0]       set_mask_s;
   logic [31:0]       clr_mask_s;
   logic [31:0]       busy_next_s;

   // Round-robin search from ptr with wrap; the first valid requester wins.
   always_comb begin
      found_s   = 1'b0;
      gnt_idx_s = '0;
      cand_s    = '0;
      grant_s   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_s = PTR_W'((32'(ptr_r) + 32'(k)) % 32'(N_REQ));
         if (!found_s && req_valid[cand_s]) begin
            found_s   = 1'b1;
            gnt_idx_s = cand_s;
         end else begin
            found_s   = found_s;
         end
      end
      if (found_s) begin
         grant_s[gnt_idx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   // One-hot AND-OR mux of the granted requester's address and data.
   always_comb begin
      sel_addr_s = '0;
      sel_data_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_addr_s = sel_addr_s | ({ADDR_W{grant_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
         sel_data_s = sel_data_s | ({DATA_W{grant_s[i]}} & req_data[i*DATA_W +: DATA_W]);
      end
   end

   assign req_ready = grant_s;

   // Pointer moves past the winner; it holds when nobody is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= '0;
      end else if (found_s) begin
         ptr_r <= (gnt_idx_s == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
      end
   end

   // Registered write port; r0 handshakes are consumed without a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (found_s && (sel_addr_s != '0)) begin
         wr_en   <= 1'b1;
         wr_addr <= sel_addr_s;
         wr_data <= sel_data_s;
      end else begin
         wr_en   <= 1'b0;
      end
   end

   assign claim_ready = claim_valid & ~busy_r[claim_addr];

   // Scoreboard update: a claim on the clearing edge re-sets the bit (set wins).
   always_comb begin
      set_mask_s  = 32'h0000_0000;
      clr_mask_s  = 32'h0000_0000;
      if (claim_ready && (claim_addr != '0)) begin
         set_mask_s = 32'd1 << claim_addr;
      end else begin
         set_mask_s = 32'h0000_0000;
      end
      if (wr_en) begin
         clr_mask_s = 32'd1 << wr_addr;
      end else begin
         clr_mask_s = 32'h0000_0000;
      end
      busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
   end

   // Pending-register vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 32'h0000_0000;
      end else begin
         busy_r <= busy_next_s;
      end
   end

   assign busy  = busy_r;
   assign stall = ((rs_addr != '0) & busy_r[rs_addr]) | ((rt_addr != '0) & busy_r[rt_addr]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write-port
// latency, r0 handling, scoreboard claim/clear and RAW stall behaviour.
module tb_regfile_wb_arbiter;

   localparam int N_REQ  = 3;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;

   logic                    clk;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic                    claim_valid;
   logic [ADDR_W-1:0]       claim_addr;
   logic                    claim_ready;
   logic [ADDR_W-1:0]       rs_addr;
   logic [ADDR_W-1:0]       rt_addr;
   logic                    stall;
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [DATA_W-1:0]       wr_data;
   logic [31:0]             busy;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data),
      .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .stall(stall),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic claim(input logic [ADDR_W-1:0] a);
      claim_valid = 1'b1;
      claim_addr  = a;
      #1;
      n_checks++;
      if (claim_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL claim_ready_r%0d: got %b expected 1", a, claim_ready);
      end
      step();
      claim_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #13;
      n_checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_wr: got en=%b addr=%0d data=%h expected 0/0/0", wr_en, wr_addr, wr_data);
      end
      n_checks++;
      if (busy !== 32'h0000_0000 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got busy=%h stall=%b expected 0/0", busy, stall);
      end
      n_checks++;
      if (req_ready !== 3'b000 || claim_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got req_ready=%b claim_ready=%b expected 000/0", req_ready, claim_ready);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset_mid;
      claim(5'd4);
      req_valid = 3'b010;
      req_addr[1*ADDR_W +: ADDR_W] = 5'd4;
      req_data[1*DATA_W +: DATA_W] = 64'h55;
      #1;
      n_checks++;
      if (req_ready !== 3'b010) begin
         n_fail++;
         $display("FAIL rstmid_grant: got %b expected 010", req_ready);
      end
      step();
      req_valid = 3'b000;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd4 || busy !== 32'h0000_0010) begin
         n_fail++;
         $display("FAIL rstmid_pre: got en=%b addr=%0d busy=%h expected 1/4/00000010", wr_en, wr_addr, busy);
      end
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (wr_en !== 1'b0 || busy !== 32'h0000_0000 || wr_addr !== 5'd0) begin
         n_fail++;
         $display("FAIL rstmid_async: got en=%b addr=%0d busy=%h expected 0/0/0", wr_en, wr_addr, busy);
      end
      #1;
      rst = 1'b0;
      req_valid = 3'b111;
      #1;
      n_checks++;
      if (req_ready !== 3'b001) begin
         n_fail++;
         $display("FAIL rstmid_ptr: got %b expected 001", req_ready);
      end
      req_valid = 3'b000;
      step();
   endtask

   task automatic test_round_robin;
      logic [2:0] exp_gnt;
      claim(5'd1);
      claim(5'd2);
      claim(5'd3);
      n_checks++;
      if (busy !== 32'h0000_000E) begin
         n_fail++;
         $display("FAIL rr_claims: got busy=%h expected 0000000e", busy);
      end
      for (int i = 0; i < N_REQ; i++) begin
         req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i + 1);
         req_data[i*DATA_W +: DATA_W] = 64'h100 + 64'(i);
      end
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         exp_gnt = 3'b001 << (c % 3);
         #1;
         n_checks++;
         if (req_ready !== exp_gnt) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: got %b expected %b", c, req_ready, exp_gnt);
         end
         step();
         n_checks++;
         if (wr_en !== 1'b1 || wr_addr !== 5'(c % 3 + 1) || wr_data !== 64'h100 + 64'(c % 3)) begin
            n_fail++;
            $display("FAIL rr_write_%0d: got en=%b addr=%0d data=%h expected 1/%0d/%h",
                     c, wr_en, wr_addr, wr_data, c % 3 + 1, 64'h100 + 64'(c % 3));
         end
      end
      req_valid = 3'b000;
      step();
      n_checks++;
      if (wr_en !== 1'b0 || busy !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL rr_drain: got en=%b busy=%h expected 0/0", wr_en, busy);
      end
   endtask

   task automatic test_r0_write;
      claim(5'd6);
      req_valid = 3'b010;
      req_addr[1*ADDR_W +: ADDR_W] = 5'd0;
      req_data[1*DATA_W +: DATA_W] = 64'hDEAD;
      #1;
      n_checks++;
      if (req_ready !== 3'b010) begin
         n_fail++;
         $display("FAIL r0_grant: got %b expected 010", req_ready);
      end
      step();
      req_valid = 3'b000;
      n_checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd3 || busy !== 32'h0000_0040) begin
         n_fail++;
         $display("FAIL r0_nowrite: got en=%b addr=%0d busy=%h expected 0/3/00000040", wr_en, wr_addr, busy);
      end
      step();
      n_checks++;
      if (wr_en !== 1'b0 || req_ready !== 3'b000 || busy !== 32'h0000_0040) begin
         n_fail++;
         $display("FAIL r0_after: got en=%b ready=%b busy=%h expected 0/000/00000040", wr_en, req_ready, busy);
      end
   endtask

   task automatic test_raw_stall;
      claim_valid = 1'b1;
      claim_addr  = 5'd5;
      rs_addr     = 5'd5;
      #1;
      n_checks++;
      if (stall !== 1'b0 || claim_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_c0: got stall=%b claim_ready=%b expected 0/1", stall, claim_ready);
      end
      step();
      claim_valid = 1'b0;
      n_checks++;
      if (stall !== 1'b1 || busy !== 32'h0000_0060) begin
         n_fail++;
         $display("FAIL raw_c1: got stall=%b busy=%h expected 1/00000060", stall, busy);
      end
      step();
      rt_addr = 5'd6;
      rs_addr = 5'd0;
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_rt: got stall=%b expected 1", stall);
      end
      rt_addr = 5'd0;
      rs_addr = 5'd5;
      step();
      req_valid = 3'b100;
      req_addr[2*ADDR_W +: ADDR_W] = 5'd5;
      req_data[2*DATA_W +: DATA_W] = 64'h1234;
      #1;
      n_checks++;
      if (req_ready !== 3'b100 || stall !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_c3: got ready=%b stall=%b expected 100/1", req_ready, stall);
      end
      step();
      req_valid = 3'b000;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'h1234 || stall !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_c4: got en=%b addr=%0d data=%h stall=%b expected 1/5/1234/1",
                  wr_en, wr_addr, wr_data, stall);
      end
      step();
      n_checks++;
      if (stall !== 1'b0 || wr_en !== 1'b0 || busy !== 32'h0000_0040) begin
         n_fail++;
         $display("FAIL raw_c5: got stall=%b en=%b busy=%h expected 0/0/00000040", stall, wr_en, busy);
      end
      rs_addr = 5'd0;
   endtask

   task automatic test_collision;
      claim(5'd7);
      req_valid = 3'b001;
      req_addr[0*ADDR_W +: ADDR_W] = 5'd7;
      req_data[0*DATA_W +: DATA_W] = 64'h77;
      step();
      req_valid   = 3'b000;
      claim_valid = 1'b1;
      claim_addr  = 5'd7;
      #1;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd7 || claim_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_block: got en=%b addr=%0d claim_ready=%b expected 1/7/0", wr_en, wr_addr, claim_ready);
      end
      step();
      n_checks++;
      if (claim_ready !== 1'b1 || busy !== 32'h0000_0040) begin
         n_fail++;
         $display("FAIL coll_retry: got claim_ready=%b busy=%h expected 1/00000040", claim_ready, busy);
      end
      step();
      claim_valid = 1'b0;
      n_checks++;
      if (busy !== 32'h0000_00C0) begin
         n_fail++;
         $display("FAIL coll_reset_bit: got busy=%h expected 000000c0", busy);
      end
      // Unclaimed write to r9 colliding with a claim of r9: set must win.
      req_valid = 3'b010;
      req_addr[1*ADDR_W +: ADDR_W] = 5'd9;
      req_data[1*DATA_W +: DATA_W] = 64'h99;
      #1;
      n_checks++;
      if (req_ready !== 3'b010) begin
         n_fail++;
         $display("FAIL setwin_grant: got %b expected 010", req_ready);
      end
      step();
      req_valid   = 3'b000;
      claim_valid = 1'b1;
      claim_addr  = 5'd9;
      #1;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd9 || claim_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL setwin_claim: got en=%b addr=%0d claim_ready=%b expected 1/9/1", wr_en, wr_addr, claim_ready);
      end
      step();
      claim_valid = 1'b0;
      n_checks++;
      if (busy !== 32'h0000_02C0) begin
         n_fail++;
         $display("FAIL setwin_busy: got busy=%h expected 000002c0", busy);
      end
   endtask

   task automatic test_pointer_hold;
      req_valid = 3'b100;
      req_addr[2*ADDR_W +: ADDR_W] = 5'd6;
      req_data[2*DATA_W +: DATA_W] = 64'h66;
      #1;
      n_checks++;
      if (req_ready !== 3'b100) begin
         n_fail++;
         $display("FAIL hold_grant2: got %b expected 100", req_ready);
      end
      step();
      req_valid = 3'b000;
      step();
      step();
      step();
      n_checks++;
      if (wr_en !== 1'b0 || busy !== 32'h0000_0280) begin
         n_fail++;
         $display("FAIL hold_idle: got en=%b busy=%h expected 0/00000280", wr_en, busy);
      end
      req_valid = 3'b101;
      req_addr[0*ADDR_W +: ADDR_W] = 5'd7;
      req_addr[2*ADDR_W +: ADDR_W] = 5'd9;
      #1;
      n_checks++;
      if (req_ready !== 3'b001) begin
         n_fail++;
         $display("FAIL hold_first: got %b expected 001", req_ready);
      end
      step();
      req_valid = 3'b100;
      #1;
      n_checks++;
      if (req_ready !== 3'b100 || wr_addr !== 5'd7) begin
         n_fail++;
         $display("FAIL hold_second: got ready=%b wr_addr=%0d expected 100/7", req_ready, wr_addr);
      end
      step();
      req_valid = 3'b000;
      n_checks++;
      if (wr_addr !== 5'd9 || wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_wr9: got en=%b addr=%0d expected 1/9", wr_en, wr_addr);
      end
      step();
      n_checks++;
      if (busy !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL hold_busy: got busy=%h expected 0", busy);
      end
   endtask

   initial begin
      rst         = 1'b0;
      req_valid   = 3'b000;
      req_addr    = '0;
      req_data    = '0;
      claim_valid = 1'b0;
      claim_addr  = 5'd0;
      rs_addr     = 5'd0;
      rt_addr     = 5'd0;
      test_reset();
      test_reset_mid();
      test_round_robin();
      test_r0_write();
      test_raw_stall();
      test_collision();
      test_pointer_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
